// File: rtl/stream_gate_arbiter_if.sv
// Stream bundle between the requester streams, the arbiter and
// the accelerator adapter input.
interface stream_gate_arbiter_if #(
    parameter int NUM_IN          = 4,
    parameter int TDATA_NUM_BYTES = 8
);
    localparam int DW = TDATA_NUM_BYTES * 8;

    logic [NUM_IN*DW-1:0] in_tdata;
    logic [NUM_IN-1:0]    in_tlast;
    logic [NUM_IN-1:0]    in_tvalid;
    logic [NUM_IN-1:0]    in_tready;
    logic [DW-1:0]        out_tdata;
    logic                 out_tlast;
    logic                 out_tvalid;
    logic                 out_tready;

    modport master (
        input  in_tdata, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tlast, out_tvalid
    );

    modport slave (
        output in_tdata, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tlast, out_tvalid
    );
endinterface

// File: rtl/stream_gate_arbiter.sv
// Packet-granular round-robin arbiter that admits a fixed budget of
// tlast-delimited packets from NUM_IN requesters into one stream.
module stream_gate_arbiter #(
    parameter int NUM_IN          = 4,
    parameter int TDATA_NUM_BYTES = 8,
    parameter int CNT_W           = 8
) (
    input  logic              s_axis_aclk,
    input  logic              s_axi_aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  pkt_count,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkts_done,
    output logic [NUM_IN-1:0] grant,
    stream_gate_arbiter_if.master bus
);
    localparam int DW = TDATA_NUM_BYTES * 8;
    localparam int IW = $clog2(NUM_IN);
    localparam int JW = IW + 1;

    typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [CNT_W-1:0] remaining;
    logic             abort_pend;
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic [JW-1:0]    j;
    logic             fire_last;

    // first valid requester after the RR pointer, wrapping
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        j       = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            j = {1'b0, ptr} + JW'(k);
            if (j >= JW'(NUM_IN))
                j = j - JW'(NUM_IN);
            if (!hit && bus.in_tvalid[j[IW-1:0]]) begin
                hit     = 1'b1;
                hit_idx = j[IW-1:0];
            end
        end
    end

    // zero-latency pass-through of the granted requester
    always_comb begin
        bus.out_tdata  = '0;
        bus.out_tlast  = 1'b0;
        bus.out_tvalid = 1'b0;
        bus.in_tready  = '0;
        if (state == XFER) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (gidx == IW'(i)) begin
                    bus.out_tdata    = bus.in_tdata[i*DW +: DW];
                    bus.out_tlast    = bus.in_tlast[i];
                    bus.out_tvalid   = bus.in_tvalid[i];
                    bus.in_tready[i] = bus.out_tready;
                end
            end
        end
    end

    assign fire_last = (state == XFER) & bus.out_tvalid &
                       bus.out_tready & bus.out_tlast;

    // command sequencing, packet accounting and grant registers
    always_ff @(posedge s_axis_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pkts_done  <= '0;
            grant      <= '0;
            ptr        <= IW'(NUM_IN - 1);
            gidx       <= '0;
            remaining  <= '0;
            abort_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining  <= pkt_count;
                        pkts_done  <= '0;
                        busy       <= 1'b1;
                        abort_pend <= 1'b0;
                        state      <= (pkt_count != '0) ? ARB : DONE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARB: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (hit) begin
                        grant <= NUM_IN'(1) << hit_idx;
                        gidx  <= hit_idx;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (abort)
                        abort_pend <= 1'b1;
                    if (fire_last) begin
                        ptr       <= gidx;
                        grant     <= '0;
                        remaining <= remaining - CNT_W'(1);
                        if (pkts_done != '1)
                            pkts_done <= pkts_done + CNT_W'(1);
                        if (remaining == CNT_W'(1) || abort_pend || abort)
                            state <= DONE;
                        else
                            state <= ARB;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_gate_arbiter.sv
// Directed bench for stream_gate_arbiter with requester models
// and a beat/grant scoreboard.
module tb_stream_gate_arbiter;
    localparam int N  = 4;
    localparam int NB = 8;
    localparam int CW = 8;
    localparam int DW = NB * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] pkt_count;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkts_done;
    logic [N-1:0]  grant;

    stream_gate_arbiter_if #(.NUM_IN(N), .TDATA_NUM_BYTES(NB)) bus ();

    stream_gate_arbiter #(
        .NUM_IN(N), .TDATA_NUM_BYTES(NB), .CNT_W(CW)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axi_aresetn (rst_n),
        .start         (start),
        .abort         (abort),
        .pkt_count     (pkt_count),
        .busy          (busy),
        .done          (done),
        .pkts_done     (pkts_done),
        .grant         (grant),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;

    logic [DW:0] exp_q[$];
    int          gq[$];

    int pkts_left[N];
    int beat[N];
    int seq[N];
    int len[N];
    int cfg_pkts[N];
    int cfg_len;
    bit cfg_load = 1'b0;
    bit fire[N];

    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] er;
    logic [DW:0]  e;
    int           g;

    function automatic logic [DW-1:0] mk(input int r, input int s, input int b);
        return {8'hA5, 8'(r), 16'(s), 32'(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic load_src(input int p0, input int p1, input int p2,
                            input int p3, input int l);
        cfg_pkts[0] = p0;
        cfg_pkts[1] = p1;
        cfg_pkts[2] = p2;
        cfg_pkts[3] = p3;
        cfg_len     = l;
        cfg_load    = 1'b1;
        step;
        cfg_load    = 1'b0;
    endtask

    task automatic push_pkt(input int r, input int s, input int l);
        for (int b = 0; b < l; b++)
            exp_q.push_back({(b == l - 1), mk(r, s, b)});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            step;
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_cmd(input int n, output int cyc);
        pkt_count = CW'(n);
        start     = 1'b1;
        step;
        start     = 1'b0;
        wait_done(cyc);
        cyc++;
    endtask

    // requester stream sources
    always_comb begin
        bus.in_tvalid = '0;
        bus.in_tlast  = '0;
        bus.in_tdata  = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_tvalid[i]           = pkts_left[i] > 0;
            bus.in_tlast[i]            = beat[i] == len[i] - 1;
            bus.in_tdata[i*DW +: DW]   = mk(i, seq[i], beat[i]);
        end
    end

    always @(negedge clk)
        for (int i = 0; i < N; i++)
            fire[i] = bus.in_tvalid[i] & bus.in_tready[i];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (cfg_load) begin
                pkts_left[i] = cfg_pkts[i];
                beat[i]      = 0;
                seq[i]       = 0;
                len[i]       = cfg_len;
            end else if (fire[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    seq[i]++;
                    pkts_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
    end

    // output monitor against the scoreboard
    always @(negedge clk) begin
        er = grant & {N{bus.out_tready}};
        chk("tready_map", bus.in_tready, er);
        chk("tvalid_map", bus.out_tvalid, |(grant & bus.in_tvalid));
        if (grant != '0 && prev_grant == '0) begin
            chk("grant_q_nonempty", gq.size() != 0, 1);
            if (gq.size() != 0) begin
                g = gq.pop_front();
                chk("grant_order", grant, 64'(1) << g);
            end
        end
        prev_grant = grant;
        if (bus.out_tvalid && bus.out_tready) begin
            n_beats++;
            chk("beat_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", bus.out_tdata, e[DW-1:0]);
                chk("beat_last", bus.out_tlast, e[DW]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int b0;
        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        pkt_count      = '0;
        bus.out_tready = 1'b1;
        repeat (3) step;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_grant", grant, 0);
        chk("rst_tready", bus.in_tready, 0);
        chk("rst_tvalid", bus.out_tvalid, 0);
        chk("rst_pkts", pkts_done, 0);
        rst_n = 1'b1;
        step;

        // round robin, all requesters valid
        load_src(3, 3, 3, 3, 2);
        for (int k = 0; k < 8; k++) begin
            gq.push_back(k % 4);
            push_pkt(k % 4, k / 4, 2);
        end
        run_cmd(8, n);
        chk("rr_cycles", n, 26);
        chk("rr_busy_at_done", busy, 1);
        chk("rr_pkts", pkts_done, 8);
        step;
        chk("rr_done_once", done, 0);
        chk("rr_busy_off", busy, 0);
        chk("rr_q_empty", exp_q.size(), 0);
        load_src(0, 0, 0, 0, 1);

        // single requester, three 4-beat packets
        load_src(3, 0, 0, 0, 4);
        for (int s = 0; s < 3; s++) begin
            gq.push_back(0);
            push_pkt(0, s, 4);
        end
        b0 = n_beats;
        run_cmd(3, n);
        chk("single_cycles", n, 17);
        chk("single_pkts", pkts_done, 3);
        step;
        chk("single_done_once", done, 0);
        chk("single_grant", grant, 0);
        chk("single_beats", n_beats - b0, 12);
        chk("single_q_empty", exp_q.size(), 0);

        // backpressure on requester 2
        load_src(0, 0, 1, 0, 6);
        gq.push_back(2);
        push_pkt(2, 0, 6);
        b0        = n_beats;
        pkt_count = 1;
        start     = 1'b1;
        step;
        start     = 1'b0;
        n         = 0;
        while (done !== 1'b1 && n < 200) begin
            bus.out_tready = (n % 2 == 0);
            if (grant == 4'b0100)
                chk("bp_tvalid_held", bus.out_tvalid, 1);
            step;
            n++;
        end
        chk("bp_done_seen", done, 1);
        bus.out_tready = 1'b1;
        chk("bp_beats", n_beats - b0, 6);
        chk("bp_pkts", pkts_done, 1);
        chk("bp_q_empty", exp_q.size(), 0);
        step;

        // abort on second beat of a 5-beat packet
        load_src(0, 3, 0, 0, 5);
        gq.push_back(1);
        push_pkt(1, 0, 5);
        pkt_count = 4;
        start     = 1'b1;
        step;
        start     = 1'b0;
        n         = 0;
        while (grant == '0 && n < 20) begin
            step;
            n++;
        end
        chk("abort_grant", grant, 4'b0010);
        step;
        abort = 1'b1;
        step;
        abort = 1'b0;
        wait_done(n);
        chk("abort_pkts", pkts_done, 1);
        step;
        chk("abort_busy_off", busy, 0);
        repeat (3) step;
        chk("abort_idle_grant", grant, 0);
        chk("abort_q_empty", exp_q.size(), 0);

        // zero packet budget
        pkt_count = 0;
        start     = 1'b1;
        step;
        start     = 1'b0;
        chk("zero_busy_c1", busy, 1);
        chk("zero_done_c1", done, 0);
        chk("zero_grant_c1", grant, 0);
        step;
        chk("zero_done_c2", done, 1);
        chk("zero_busy_c2", busy, 1);
        chk("zero_grant_c2", grant, 0);
        chk("zero_pkts", pkts_done, 0);
        step;
        chk("zero_done_c3", done, 0);
        chk("zero_busy_c3", busy, 0);
        load_src(0, 0, 0, 0, 1);

        // start pulsed while busy is ignored
        load_src(0, 4, 0, 0, 2);
        gq.push_back(1);
        gq.push_back(1);
        push_pkt(1, 0, 2);
        push_pkt(1, 1, 2);
        pkt_count = 2;
        start     = 1'b1;
        step;
        start     = 1'b0;
        step;
        step;
        pkt_count = 5;
        start     = 1'b1;
        step;
        start     = 1'b0;
        wait_done(n);
        chk("busy_start_pkts", pkts_done, 2);
        repeat (5) step;
        chk("busy_start_grant", grant, 0);
        chk("busy_start_busy", busy, 0);
        chk("busy_start_q_empty", exp_q.size(), 0);
        load_src(0, 0, 0, 0, 1);

        // reset asserted mid-packet
        load_src(0, 0, 0, 2, 4);
        gq.push_back(3);
        exp_q.push_back({1'b0, mk(3, 0, 0)});
        exp_q.push_back({1'b0, mk(3, 0, 1)});
        pkt_count = 2;
        start     = 1'b1;
        step;
        start     = 1'b0;
        n         = 0;
        while (grant == '0 && n < 20) begin
            step;
            n++;
        end
        chk("rstx_grant_pre", grant, 4'b1000);
        step;
        step;
        rst_n = 1'b0;
        #1;
        chk("rstx_grant", grant, 0);
        chk("rstx_tready", bus.in_tready, 0);
        chk("rstx_tvalid", bus.out_tvalid, 0);
        chk("rstx_busy", busy, 0);
        load_src(1, 0, 1, 1, 2);
        rst_n = 1'b1;
        step;
        gq.push_back(0);
        push_pkt(0, 0, 2);
        run_cmd(1, n);
        chk("rstx_pkts", pkts_done, 1);
        step;
        chk("rstx_q_empty", exp_q.size(), 0);
        chk("final_gq_empty", gq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
